// File: rtl/univ_shift_reg_p.sv
// Parametrised universal shift register with immediate and counted burst modes.
// A burst latches op/count on start, shifts once per edge, then pulses done.
module univ_shift_reg_p #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] pi,
    input  logic             si,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] po,
    output logic             so_l,
    output logic             so_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OpHold  = 3'b000;
    localparam logic [2:0] OpShl   = 3'b001;
    localparam logic [2:0] OpShr   = 3'b010;
    localparam logic [2:0] OpLoad  = 3'b011;
    localparam logic [2:0] OpRotl  = 3'b100;
    localparam logic [2:0] OpRotr  = 3'b101;
    localparam logic [2:0] OpAshr  = 3'b110;
    localparam logic [2:0] OpClear = 3'b111;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] po_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] rem_q;
    logic             busy_q;
    logic             done_q;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       sel,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] par,
                                                  input logic             ser);
        logic [WIDTH-1:0] res;
        res = cur;
        unique case (sel)
            OpHold:  res = cur;
            OpShl:   res = {cur[WIDTH-2:0], ser};
            OpShr:   res = {ser, cur[WIDTH-1:1]};
            OpLoad:  res = par;
            OpRotl:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            OpRotr:  res = {cur[0], cur[WIDTH-1:1]};
            OpAshr:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            OpClear: res = '0;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Hold, load and clear are idempotent, so a burst of them collapses to one step.
    function automatic logic is_repeatable(input logic [2:0] sel);
        return !(sel == OpHold || sel == OpLoad || sel == OpClear);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            po_q    <= '0;
            op_q    <= OpHold;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q <= op;
                        if (count != '0) begin
                            po_q <= apply_op(op, po_q, pi, si);
                        end
                        if (is_repeatable(op) && count > CNT_W'(1)) begin
                            rem_q   <= count - CNT_W'(1);
                            state_q <= StBusy;
                            busy_q  <= 1'b1;
                        end else begin
                            rem_q  <= '0;
                            done_q <= 1'b1;
                        end
                    end else begin
                        po_q <= apply_op(op, po_q, pi, si);
                    end
                end
                StBusy: begin
                    // Live op/pi are ignored here; only si feeds the latched shift.
                    po_q  <= apply_op(op_q, po_q, pi, si);
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign po   = po_q;
    assign so_l = po_q[WIDTH-1];
    assign so_r = po_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Directed bench for univ_shift_reg_p: a per-cycle vector table plus
// hand-written mid-burst reset and back-to-back burst sequences.
module tb_univ_shift_reg_p;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       op;
    logic [WIDTH-1:0] pi;
    logic             si;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] po;
    logic             so_l;
    logic             so_r;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string            name;
        logic             rst;
        logic [2:0]       op;
        logic [WIDTH-1:0] pi;
        logic             si;
        logic             start;
        logic [CNT_W-1:0] count;
        logic [WIDTH-1:0] exp_po;
        logic             exp_busy;
        logic             exp_done;
    } vec_t;

    vec_t vecs[$];

    univ_shift_reg_p #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .op   (op),
        .pi   (pi),
        .si   (si),
        .start(start),
        .count(count),
        .po   (po),
        .so_l (so_l),
        .so_r (so_r),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic add(input string n, input logic r, input logic [2:0] o,
                       input logic [WIDTH-1:0] p, input logic s, input logic st,
                       input logic [CNT_W-1:0] c, input logic [WIDTH-1:0] ep,
                       input logic eb, input logic ed);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.pi = p; v.si = s; v.start = st;
        v.count = c; v.exp_po = ep; v.exp_busy = eb; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [2:0] o, input logic [WIDTH-1:0] p,
                         input logic s, input logic st, input logic [CNT_W-1:0] c);
        rst = r; op = o; pi = p; si = s; start = st; count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input logic [WIDTH-1:0] ep,
                         input logic eb, input logic ed);
        checks++;
        if (po !== ep) begin
            errors++;
            $display("FAIL %s po: got %h expected %h", n, po, ep);
        end
        checks++;
        if (busy !== eb) begin
            errors++;
            $display("FAIL %s busy: got %b expected %b", n, busy, eb);
        end
        checks++;
        if (done !== ed) begin
            errors++;
            $display("FAIL %s done: got %b expected %b", n, done, ed);
        end
        checks++;
        if (so_l !== ep[WIDTH-1] || so_r !== ep[0]) begin
            errors++;
            $display("FAIL %s so_l/so_r: got %b/%b expected %b/%b", n, so_l, so_r,
                     ep[WIDTH-1], ep[0]);
        end
    endtask

    initial begin
        // name, rst, op, pi, si, start, count, exp_po, exp_busy, exp_done
        add("init_rst",   1, 3'b000, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        add("load_a5",    0, 3'b011, 8'hA5, 0, 0, 4'd0, 8'hA5, 0, 0);
        add("rst_ovr",    1, 3'b001, 8'h00, 1, 1, 4'd3, 8'h00, 0, 0);
        add("post_rst",   0, 3'b000, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        add("load_96",    0, 3'b011, 8'h96, 0, 0, 4'd0, 8'h96, 0, 0);
        add("shl_si1",    0, 3'b001, 8'h00, 1, 0, 4'd0, 8'h2D, 0, 0);
        add("shr_si0",    0, 3'b010, 8'h00, 0, 0, 4'd0, 8'h16, 0, 0);
        add("rotr",       0, 3'b101, 8'h00, 0, 0, 4'd0, 8'h0B, 0, 0);
        add("load_80",    0, 3'b011, 8'h80, 0, 0, 4'd0, 8'h80, 0, 0);
        add("ashr",       0, 3'b110, 8'h00, 0, 0, 4'd0, 8'hC0, 0, 0);
        add("load_81",    0, 3'b011, 8'h81, 0, 0, 4'd0, 8'h81, 0, 0);
        add("rotl",       0, 3'b100, 8'h00, 0, 0, 4'd0, 8'h03, 0, 0);
        add("clear",      0, 3'b111, 8'hFF, 1, 0, 4'd0, 8'h00, 0, 0);
        add("shr_si1",    0, 3'b010, 8'h00, 1, 0, 4'd0, 8'h80, 0, 0);
        add("hold",       0, 3'b000, 8'h55, 1, 0, 4'd0, 8'h80, 0, 0);
        add("load_01",    0, 3'b011, 8'h01, 0, 0, 4'd0, 8'h01, 0, 0);
        add("brot_e0",    0, 3'b100, 8'h00, 0, 1, 4'd3, 8'h02, 1, 0);
        add("brot_e1",    0, 3'b011, 8'hFF, 0, 1, 4'd7, 8'h04, 1, 0);
        add("brot_e2",    0, 3'b011, 8'hFF, 0, 0, 4'd0, 8'h08, 0, 1);
        add("brot_idle",  0, 3'b000, 8'h00, 0, 0, 4'd0, 8'h08, 0, 0);
        add("cnt0",       0, 3'b001, 8'h00, 1, 1, 4'd0, 8'h08, 0, 1);
        add("cnt0_after", 0, 3'b000, 8'h00, 0, 0, 4'd0, 8'h08, 0, 0);
        add("clr2",       0, 3'b111, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        add("cnt1",       0, 3'b001, 8'h00, 1, 1, 4'd1, 8'h01, 0, 1);
        add("cnt1_after", 0, 3'b000, 8'h00, 0, 0, 4'd0, 8'h01, 0, 0);
        add("bload5",     0, 3'b011, 8'h3C, 0, 1, 4'd5, 8'h3C, 0, 1);
        add("bload_aft",  0, 3'b000, 8'hAA, 0, 0, 4'd0, 8'h3C, 0, 0);
        add("bload_aft2", 0, 3'b000, 8'hAA, 0, 0, 4'd0, 8'h3C, 0, 0);

        rst = 1'b1; op = 3'b000; pi = '0; si = 1'b0; start = 1'b0; count = '0;
        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].pi, vecs[i].si, vecs[i].start,
                  vecs[i].count);
            check(vecs[i].name, vecs[i].exp_po, vecs[i].exp_busy, vecs[i].exp_done);
        end

        // Reset four edges into a 10-shift SHR burst; the aborted burst must never signal done.
        drive(0, 3'b111, 8'h00, 0, 0, 4'd0);
        check("mr_clear", 8'h00, 0, 0);
        drive(0, 3'b010, 8'h00, 1, 1, 4'd10);
        check("mr_e0", 8'h80, 1, 0);
        drive(0, 3'b011, 8'h00, 1, 0, 4'd0);
        check("mr_e1", 8'hC0, 1, 0);
        drive(0, 3'b011, 8'h00, 1, 0, 4'd0);
        check("mr_e2", 8'hE0, 1, 0);
        drive(0, 3'b011, 8'h00, 1, 0, 4'd0);
        check("mr_e3", 8'hF0, 1, 0);
        drive(1, 3'b011, 8'h00, 1, 0, 4'd0);
        check("mr_rst", 8'h00, 0, 0);
        for (int k = 0; k < 12; k++) begin
            drive(0, 3'b000, 8'h00, 1, 0, 4'd0);
            check("mr_quiet", 8'h00, 0, 0);
        end

        // Second burst issued in the done cycle of the first.
        drive(0, 3'b011, 8'h81, 0, 0, 4'd0);
        check("bb_load", 8'h81, 0, 0);
        drive(0, 3'b001, 8'h00, 0, 1, 4'd2);
        check("bb_a0", 8'h02, 1, 0);
        drive(0, 3'b000, 8'h00, 0, 0, 4'd0);
        check("bb_a1", 8'h04, 0, 1);
        drive(0, 3'b101, 8'h00, 0, 1, 4'd2);
        check("bb_b0", 8'h02, 1, 0);
        drive(0, 3'b000, 8'h00, 0, 0, 4'd0);
        check("bb_b1", 8'h01, 0, 1);
        drive(0, 3'b000, 8'h00, 0, 0, 4'd0);
        check("bb_idle", 8'h01, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg_p.md
# univ_shift_reg_p

Parametrised universal shift register that succeeds the fixed 5-bit part. It adds configurable width, rotate and arithmetic-shift modes, a synchronous clear, and a counted burst mode. In burst mode a single start request shifts the register N times under an internal down-counter, with busy/done handshake outputs. It sits in datapath front-ends: serial/parallel conversion, bit-serial arithmetic, and barrel-shift-by-iteration.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of burst count port; max burst = 2^CNT_W − 1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- op  in  3  operation select (encoding below)
- pi  in  WIDTH  parallel load data
- si  in  1  serial input bit
- start  in  1  burst request; sampled only in IDLE
- count  in  CNT_W  number of burst shifts; sampled with start
- po  out  WIDTH  register contents (registered)
- so_l  out  1  po[WIDTH-1] (combinational from po)
- so_r  out  1  po[0] (combinational from po)
- busy  out  1  burst in progress (registered)
- done  out  1  one-cycle burst-complete pulse (registered)

## Operation
- op encoding:
  - 000 hold
  - 001 SHL: {po[W-2:0], si}
  - 010 SHR logical: {si, po[W-1:1]}
  - 011 LOAD: pi
  - 100 ROTL: {po[W-2:0], po[W-1]}
  - 101 ROTR: {po[0], po[W-1:1]}
  - 110 ASHR: {po[W-1], po[W-1:1]}
  - 111 CLEAR: 0
- States:
  - IDLE
  - BUSY
- IDLE, start=0: op applied every edge (immediate mode).
- IDLE, start=1:
  - Latch op into op_q and count into rem.
  - If count ≥ 1, apply op once at this edge.
  - If count ≥ 2, set rem = count−1 and go to BUSY.
  - If count ≤ 1, stay in IDLE and set done=1 for the next cycle.
- Burst with count=0: po unchanged, no busy, done pulses for one cycle.
- Burst with a non-shift op (000, 011, 111): executes exactly once regardless of count (count=0 still means no change), then done. BUSY is never entered.
- BUSY:
  - Apply op_q on every edge; live op/start/count/pi are ignored.
  - si is sampled live on each edge for SHL/SHR.
  - rem decrements each edge.
  - On the edge where rem goes 1→0, return to IDLE and set done=1.
- done is high for exactly one cycle. That cycle is IDLE, so a new start or immediate op is accepted on the same edge.
- busy = (state==BUSY). busy and done are never high together.
- Reset (any state, including mid-burst):
  - po=0, busy=0, done=0, rem=0, op_q=000, state=IDLE.
  - An aborted burst produces no done.
- No arithmetic beyond the rem decrement. rem never wraps, because BUSY exits at rem=0.

## Timing
- Immediate-mode latency: 1 cycle. po reflects the op after the edge that samples it.
- Burst of N≥1 sampled at edge k:
  - Shifts occur at edges k … k+N−1.
  - busy is high from after edge k until edge k+N−1 (N−1 cycles).
  - done is high in the cycle after edge k+N−1.
  - Minimum start-to-start spacing is N cycles.
- so_l/so_r track po with zero added latency.

## Test plan
- Reset: LOAD pi=0xA5, then rst=1 with op=001, start=1 → after the edge po=0x00, busy=0, done=0; no done afterwards.
- Immediate ops (WIDTH=8):
  - LOAD 0x96 → 0x96.
  - SHL si=1 → 0x2D.
  - SHR si=0 → 0x16.
  - ROTR → 0x0B.
  - LOAD 0x80, then ASHR → 0xC0.
  - ROTL of 0x81 → 0x03.
  - CLEAR → 0x00.
  - so_l/so_r match po[7]/po[0] throughout.
- Burst rotate:
  - Load 0x01, start op=100 count=3 → po=0x02,0x04,0x08 on 3 consecutive edges.
  - busy high 2 cycles, done high 1 cycle.
  - op toggled to 011 with pi=0xFF during BUSY leaves the sequence unaffected.
- Burst edge counts:
  - count=0 → po unchanged, busy never high, done one cycle.
  - count=1 op=001 si=1 on 0x00 → 0x01, busy never high, done one cycle.
  - op=011 with count=5 → single load, done one cycle.
- Reset mid-burst: start op=010 count=10 si=1 on 0x00, assert rst after 4 edges → po=0x00, busy=0, done never pulses.
- Back-to-back bursts:
  - In the done cycle of a 2-shift SHL burst, issue start op=101 count=2.
  - Second burst is accepted and runs with the same timing; done pulses once per burst.
